// File: rtl/ceyloniac_fetch_buffer.sv
// Two-entry FIFO between instruction memory and decode; splits the head word into MIPS fields.
// Latency: a word accepted at edge N is the head (instr_valid=1) right after edge N; no bypass.
// Backpressure: imem_ready drops only when both entries are full; decode_stall holds the head.
module ceyloniac_fetch_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int IMM_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic [ADDRESS_WIDTH-1:0] imem_pc,
  input  logic                     imem_valid,
  output logic                     imem_ready,
  input  logic                     flush,
  input  logic                     decode_stall,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr_out,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [IMM_WIDTH-1:0]     immediate,
  output logic [25:0]              jump_target
);

  logic [DATA_WIDTH-1:0]    dat_q [2];
  logic [ADDRESS_WIDTH-1:0] pc_q  [2];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;
  logic                     push, pop;

  // Ready depends on occupancy alone so memory never sees a path from decode_stall.
  assign imem_ready  = (count_q != 2'd2);
  assign instr_valid = (count_q != 2'd0);

  // A flush cancels any transfer in the same cycle.
  assign push = imem_valid & imem_ready & ~flush;
  assign pop  = instr_valid & ~decode_stall & ~flush;

  // Head entry and its field slices; when empty these show a stale entry.
  assign instr_out   = dat_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign opcode      = instr_out[31:26];
  assign rs          = instr_out[25:21];
  assign rt          = instr_out[20:16];
  assign rd          = instr_out[15:11];
  assign shamt       = instr_out[10:6];
  assign funct       = instr_out[5:0];
  assign immediate   = instr_out[IMM_WIDTH-1:0];
  assign jump_target = instr_out[25:0];

  // Next-state for pointers and occupancy; flush returns everything to the origin.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; flush leaves contents in place, only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q[0] <= '0;
      dat_q[1] <= '0;
      pc_q[0]  <= '0;
      pc_q[1]  <= '0;
    end else if (push) begin
      dat_q[wr_ptr_q] <= imem_data;
      pc_q[wr_ptr_q]  <= imem_pc;
    end
  end

endmodule

// File: tb/tb_ceyloniac_fetch_buffer.sv
module tb_ceyloniac_fetch_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] imem_data;
  logic [31:0] imem_pc;
  logic        imem_valid;
  logic        imem_ready;
  logic        flush;
  logic        decode_stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] jump_target;

  ceyloniac_fetch_buffer #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .IMM_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_data(imem_data), .imem_pc(imem_pc), .imem_valid(imem_valid), .imem_ready(imem_ready),
    .flush(flush), .decode_stall(decode_stall),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .jump_target(jump_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of {pc, word} accepted but not yet consumed, capacity 2.
  logic [63:0] q [$];
  logic [31:0] next_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [63:0] hd;
    logic [31:0] w;
    chk({ctx, ".ready"}, 64'(imem_ready), 64'(q.size() != 2));
    chk({ctx, ".valid"}, 64'(instr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      hd = q[0];
      w  = hd[31:0];
      chk({ctx, ".data"},   64'(instr_out),   64'(w));
      chk({ctx, ".pc"},     64'(instr_pc),    64'(hd[63:32]));
      chk({ctx, ".opcode"}, 64'(opcode),      64'(w >> 26));
      chk({ctx, ".rs"},     64'(rs),          64'((w >> 21) & 32'h1F));
      chk({ctx, ".rt"},     64'(rt),          64'((w >> 16) & 32'h1F));
      chk({ctx, ".rd"},     64'(rd),          64'((w >> 11) & 32'h1F));
      chk({ctx, ".shamt"},  64'(shamt),       64'((w >> 6) & 32'h1F));
      chk({ctx, ".funct"},  64'(funct),       64'(w & 32'h3F));
      chk({ctx, ".imm"},    64'(immediate),   64'(w & 32'hFFFF));
      chk({ctx, ".jtgt"},   64'(jump_target), 64'(w & 32'h03FF_FFFF));
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input string ctx, input logic v, input logic [31:0] d,
                      input logic stall, input logic fl);
    bit do_push, do_pop;
    imem_valid   = v;
    imem_data    = d;
    imem_pc      = next_pc;
    decode_stall = stall;
    flush        = fl;
    do_push = v && (q.size() < 2) && !fl;
    do_pop  = (q.size() > 0) && !stall && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({next_pc, d});
    end
    if (do_push) next_pc += 32'd4;
    imem_valid = 1'b0;
    flush      = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_data = '0; imem_pc = '0;
    flush = 1'b0; decode_stall = 1'b0; next_pc = 32'h0;
    #2;
    chk("rst.valid", 64'(instr_valid), 64'd0);
    chk("rst.data",  64'(instr_out),   64'd0);
    chk("rst.pc",    64'(instr_pc),    64'd0);
    chk("rst.imm",   64'(immediate),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step("idle", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("idle.data0", 64'(instr_out), 64'd0);
    end

    // Streaming three words back-to-back
    next_pc = 32'h0;
    step("stream0", 1'b1, 32'h2008FFFC, 1'b0, 1'b0);
    chk("stream0.opcode", 64'(opcode),    64'h08);
    chk("stream0.rt",     64'(rt),        64'd8);
    chk("stream0.imm",    64'(immediate), 64'hFFFC);
    step("stream1", 1'b1, 32'h012A4020, 1'b0, 1'b0);
    chk("stream1.pc", 64'(instr_pc), 64'h4);
    step("stream2", 1'b1, 32'h08000010, 1'b0, 1'b0);
    chk("stream2.jtgt", 64'(jump_target), 64'h10);
    step("drain", 1'b0, 32'h0, 1'b0, 1'b0);

    // Fill under stall, then release
    next_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step("fill", 1'b1, $urandom, 1'b1, 1'b0);
      chk("fill.headpc", 64'(instr_pc), 64'h0);
    end
    chk("fill.ready_low", 64'(imem_ready), 64'd0);
    step("release0", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("release0.ready", 64'(imem_ready), 64'd1);
    step("release1", 1'b0, 32'h0, 1'b0, 1'b0);

    // Flush while full; word offered in flush cycle must vanish
    step("pf0", 1'b1, $urandom, 1'b1, 1'b0);
    step("pf1", 1'b1, $urandom, 1'b1, 1'b0);
    step("flush", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("flush.valid", 64'(instr_valid), 64'd0);
    step("postflush", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("postflush.valid", 64'(instr_valid), 64'd0);

    // Simultaneous push/pop at occupancy 1, wrapping pointers
    step("pp_seed", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("pushpop", 1'b1, $urandom, 1'b0, 1'b0);
      chk("pushpop.occ1", 64'(instr_valid & imem_ready), 64'd1);
    end
    step("pp_drain", 1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset between edges with two entries held
    step("ar_drain0", 1'b0, 32'h0, 1'b1, 1'b1);
    step("ar0", 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    step("ar1", 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0);
    chk("ar.full", 64'(imem_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar.valid", 64'(instr_valid), 64'd0);
    chk("ar.data",  64'(instr_out),   64'd0);
    chk("ar.pc",    64'(instr_pc),    64'd0);
    chk("ar.opcode", 64'(opcode),     64'd0);
    chk("ar.imm",   64'(immediate),   64'd0);
    chk("ar.jtgt",  64'(jump_target), 64'd0);
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    decode_stall = 1'b0;
    next_pc = 32'h100;
    step("ar_first", 1'b1, 32'h24420001, 1'b0, 1'b0);
    chk("ar_first.pc", 64'(instr_pc), 64'h100);
    step("ar_done", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ceyloniac_fetch_buffer.md
# ceyloniac_fetch_buffer

Two-entry instruction buffer between instruction memory and the decode stage. It decouples memory return timing from decode stalls. It also splits the head instruction into MIPS-style fields, including the 16-bit immediate that drives the sign extender's input. Decode sees a valid/stall interface; memory sees a valid/ready interface.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- IMM_WIDTH, 16, immediate field width; must match the sign extender IN_WIDTH

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- imem_data  input  DATA_WIDTH  instruction word from memory
- imem_pc  input  ADDRESS_WIDTH  PC of imem_data
- imem_valid  input  1  imem_data/imem_pc are valid this cycle
- imem_ready  output  1  buffer accepts a word this cycle
- flush  input  1  discard all buffered instructions (branch/jump redirect)
- decode_stall  input  1  decode cannot consume the head this cycle
- instr_valid  output  1  head entry is valid
- instr_out  output  DATA_WIDTH  head instruction
- instr_pc  output  ADDRESS_WIDTH  head PC
- opcode  output  6  instr_out[31:26]
- rs  output  5  instr_out[25:21]
- rt  output  5  instr_out[20:16]
- rd  output  5  instr_out[15:11]
- shamt  output  5  instr_out[10:6]
- funct  output  6  instr_out[5:0]
- immediate  output  IMM_WIDTH  instr_out[IMM_WIDTH-1:0]; goes to sign extender input
- jump_target  output  26  instr_out[25:0]

## Operation

- Storage: 2 entries of {pc, instruction}, plus 1-bit write pointer, 1-bit read pointer and 2-bit count (0..2).
- imem_ready = (count != 2). It is combinational from count only and never depends on decode_stall.
- push = imem_valid & imem_ready & ~flush.
  - On push, the entry at the write pointer is written and the write pointer toggles.
- pop = instr_valid & ~decode_stall & ~flush.
  - On pop, the read pointer toggles.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together
- instr_valid = (count != 0).
- instr_out/instr_pc are the entry at the read pointer; all field outputs are pure slices of instr_out.
- Full (count 2): imem_ready low, so no push even if a pop occurs that cycle. The slot frees the next cycle.
- Empty (count 0): instr_valid low. Field outputs show the stale read-pointer entry; decode must qualify them with instr_valid.
- Pointer wrap: 1-bit pointers wrap naturally (1→0).
- flush (synchronous):
  - next cycle, count=0 and both pointers=0
  - any push or pop in the flush cycle is discarded
  - entry contents are not cleared
- flush and decode_stall together: flush wins.
- reset (asynchronous, any time including mid-transfer):
  - count=0, pointers=0, all entries=0
  - instr_valid=0, all field outputs=0
  - imem_ready=1 while reset is low-going or deasserted
  - imem_ready value during reset is don't-care; the bench must not push during reset

## Timing

- Reset values:
  - instr_valid 0
  - instr_out 0, instr_pc 0, and all field outputs 0
  - imem_ready 1 after reset deasserts
- Latency: word accepted at edge N gives instr_valid=1 with that word after edge N; decode samples it at edge N+1. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained when decode_stall=0 and imem_valid=1 continuously.
- Ordering: strict FIFO. Instructions leave in acceptance order and instr_pc stays paired with its word.
- flush at edge N: instr_valid=0 after edge N. The first post-flush word is accepted at edge N+1 at the earliest.

## Test plan

- Reset then idle:
  - stimulus: reset pulse, imem_valid=0
  - response: instr_valid=0, instr_out=0, imem_ready=1 for 10 cycles
- Streaming:
  - stimulus: push 0x2008FFFC (pc 0x0), 0x012A4020 (pc 0x4), 0x08000010 (pc 0x8) back-to-back, decode_stall=0
  - response: each instr_valid exactly one cycle after acceptance, in order; the first shows opcode 0x08, rt 8, immediate 0xFFFC; the third shows jump_target 0x10
- Fill and stall:
  - stimulus: decode_stall=1, imem_valid=1 for 4 cycles
  - response: exactly 2 accepted, imem_ready=0 from the third cycle, head unchanged (pc 0x0)
  - then: release the stall
  - response: 2 pops and imem_ready=1 the cycle after the first pop
- Flush while full:
  - stimulus: assert flush for 1 cycle with imem_valid=1 and decode_stall=0
  - response: next cycle instr_valid=0 and count 0; the word offered in the flush cycle is not delivered
- Simultaneous push/pop at count 1:
  - stimulus: push and pop in the same cycle, repeated for 8 cycles
  - response: instr_valid stays 1 and count stays 1
  - the pointer wrap is exercised and the PC sequence is preserved
- Async reset mid-stream:
  - stimulus: assert reset between clock edges with count=2
  - response: instr_valid and all outputs go to 0 immediately, without waiting for a clock edge
  - after deassert, the first pushed word appears as the head
